// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined Booth multiplier / MAC unit.
package mul_pkg;

  // Operation selector; 2'b11 is reserved and is executed as MUL.
  typedef enum logic [1:0] {
    MUL_OP_MUL  = 2'd0,
    MUL_OP_MADD = 2'd1,
    MUL_OP_MSUB = 2'd2
  } mul_op_e;

  // Per-stage control record carried alongside the data slices.
  typedef struct packed {
    logic    valid;
    mul_op_e op;
  } stage_ctl_t;

  // Radix-4 Booth partial-product count for an even operand width.
  function automatic int pp_count(input int width);
    return (width / 32'sd2) + 32'sd1;
  endfunction

endpackage

// File: rtl/mul_pp_tree.sv
// Radix-4 Booth encoder and carry-save reduction to a sum/carry pair.
// Everything is modulo 2^(2*WIDTH); sum + carry equals A*B in that ring.
module mul_pp_tree
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_signed_mul,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_multiplicand,
  output logic [2*WIDTH-1:0] o_sum,
  output logic [2*WIDTH-1:0] o_carry
);
  localparam int PW  = 2 * WIDTH;
  localparam int NPP = pp_count(WIDTH);

  logic [WIDTH+1:0] w_a_ext;
  logic [WIDTH+2:0] w_a_pad;
  logic [WIDTH:0]   w_b_ext;
  logic [PW-1:0]    w_b1;
  logic [PW-1:0]    w_b2;
  logic [PW-1:0]    w_pp [NPP];
  logic [PW-1:0]    w_sum;
  logic [PW-1:0]    w_carry;
  logic [PW-1:0]    w_tmp;

  // Unsigned operands are zero-extended, so the top Booth digit is never negative.
  assign w_a_ext = {{2{i_signed_mul & i_multiplier[WIDTH-1]}}, i_multiplier};
  assign w_a_pad = {w_a_ext, 1'b0};
  assign w_b_ext = {i_signed_mul & i_multiplicand[WIDTH-1], i_multiplicand};
  assign w_b1    = {{(PW-WIDTH-1){w_b_ext[WIDTH]}}, w_b_ext};
  assign w_b2    = {w_b1[PW-2:0], 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [2:0]    w_bits;
    logic [PW-1:0] w_mag;
    logic          w_neg;
    logic [PW-1:0] w_raw;

    assign w_bits = w_a_pad[2*i +: 3];

    // Booth digit select: 0, +/-B or +/-2B, negated in two's complement.
    always_comb begin
      w_mag = '0;
      w_neg = 1'b0;
      case (w_bits)
        3'b001, 3'b010: begin w_mag = w_b1; w_neg = 1'b0; end
        3'b011:         begin w_mag = w_b2; w_neg = 1'b0; end
        3'b100:         begin w_mag = w_b2; w_neg = 1'b1; end
        3'b101, 3'b110: begin w_mag = w_b1; w_neg = 1'b1; end
        default:        begin w_mag = '0;   w_neg = 1'b0; end
      endcase
      if (w_neg) begin
        w_raw = ~w_mag + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        w_raw = w_mag;
      end
    end

    assign w_pp[i] = w_raw << (2 * i);
  end

  // Carry-save array: fold each further partial product into the sum/carry pair.
  always_comb begin
    w_sum   = w_pp[0];
    w_carry = w_pp[1];
    w_tmp   = '0;
    for (int k = 2; k < NPP; k++) begin
      w_tmp   = w_sum ^ w_carry ^ w_pp[k];
      w_carry = ((w_sum & w_carry) | (w_sum & w_pp[k]) | (w_carry & w_pp[k])) << 1;
      w_sum   = w_tmp;
    end
  end

  assign o_sum   = w_sum;
  assign o_carry = w_carry;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined Booth multiply / multiply-accumulate with valid/ready handshake,
// whole-pipe stall on output back-pressure and a synchronous CANCEL flush.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_signed_mul,
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [TAG_W-1:0]   i_in_tag,
  input  logic               i_cancel,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [2*WIDTH-1:0] o_result,
  output logic [TAG_W-1:0]   o_out_tag,
  output logic               o_busy
);
  localparam int PW   = 2 * WIDTH;
  localparam int NPRE = (STAGES > 1) ? (STAGES - 1) : 1;

  logic             w_stall;
  logic             w_accept;
  mul_op_e          w_in_op;
  logic [PW-1:0]    w_tree_sum;
  logic [PW-1:0]    w_tree_carry;
  logic [PW-1:0]    w_cpa_sum;
  logic [PW-1:0]    w_cpa_carry;
  logic [PW-1:0]    w_cpa_acc;
  logic [TAG_W-1:0] w_cpa_tag;
  stage_ctl_t       w_cpa_ctl;
  logic             w_pre_busy;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_cpa_res;
  logic             r_out_valid;
  logic [PW-1:0]    r_result;
  logic [TAG_W-1:0] r_out_tag;

  assign w_stall    = r_out_valid & ~i_out_ready;
  assign o_in_ready = ~w_stall & ~i_cancel & i_rst_n;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_in_op    = mul_op_e'(i_op);

  mul_pp_tree #(.WIDTH(WIDTH)) u_pp_tree (
    .i_signed_mul   (i_signed_mul),
    .i_multiplier   (i_multiplier),
    .i_multiplicand (i_multiplicand),
    .o_sum          (w_tree_sum),
    .o_carry        (w_tree_carry)
  );

  if (STAGES > 1) begin : g_pre
    stage_ctl_t       r_ctl   [NPRE];
    logic [PW-1:0]    r_sum   [NPRE];
    logic [PW-1:0]    r_carry [NPRE];
    logic [PW-1:0]    r_acc   [NPRE];
    logic [TAG_W-1:0] r_tag   [NPRE];

    // Carry-save slices: stage 0 captures the tree, later stages are plain copies.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int k = 0; k < NPRE; k++) begin
          r_ctl[k]   <= '{valid: 1'b0, op: MUL_OP_MUL};
          r_sum[k]   <= '0;
          r_carry[k] <= '0;
          r_acc[k]   <= '0;
          r_tag[k]   <= '0;
        end
      end else if (i_cancel) begin
        for (int k = 0; k < NPRE; k++) begin
          r_ctl[k].valid <= 1'b0;
        end
      end else if (!w_stall) begin
        r_ctl[0]   <= '{valid: w_accept, op: w_in_op};
        r_sum[0]   <= w_tree_sum;
        r_carry[0] <= w_tree_carry;
        r_acc[0]   <= i_acc;
        r_tag[0]   <= i_in_tag;
        for (int k = 1; k < NPRE; k++) begin
          r_ctl[k]   <= r_ctl[k-1];
          r_sum[k]   <= r_sum[k-1];
          r_carry[k] <= r_carry[k-1];
          r_acc[k]   <= r_acc[k-1];
          r_tag[k]   <= r_tag[k-1];
        end
      end
    end

    // Any carry-save slice holding a live op keeps the unit busy.
    always_comb begin
      w_pre_busy = 1'b0;
      for (int k = 0; k < NPRE; k++) begin
        w_pre_busy = w_pre_busy | r_ctl[k].valid;
      end
    end

    assign w_cpa_ctl   = r_ctl[NPRE-1];
    assign w_cpa_sum   = r_sum[NPRE-1];
    assign w_cpa_carry = r_carry[NPRE-1];
    assign w_cpa_acc   = r_acc[NPRE-1];
    assign w_cpa_tag   = r_tag[NPRE-1];
  end else begin : g_direct
    // Single-stage build: the final adder sits straight behind the tree.
    assign w_cpa_ctl   = '{valid: w_accept, op: w_in_op};
    assign w_cpa_sum   = w_tree_sum;
    assign w_cpa_carry = w_tree_carry;
    assign w_cpa_acc   = i_acc;
    assign w_cpa_tag   = i_in_tag;
    assign w_pre_busy  = 1'b0;
  end

  // Carry-propagate add, then optional accumulate; reserved op falls through to MUL.
  always_comb begin
    w_prod = w_cpa_sum + w_cpa_carry;
    case (w_cpa_ctl.op)
      MUL_OP_MADD: w_cpa_res = w_cpa_acc + w_prod;
      MUL_OP_MSUB: w_cpa_res = w_cpa_acc - w_prod;
      default:     w_cpa_res = w_prod;
    endcase
  end

  // Output stage: holds while stalled, dropped by CANCEL, data updated only for live ops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
    end else if (i_cancel) begin
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_cpa_ctl.valid;
      if (w_cpa_ctl.valid) begin
        r_result  <= w_cpa_res;
        r_out_tag <= w_cpa_tag;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_out_tag   = r_out_tag;
  assign o_busy      = w_pre_busy | r_out_valid;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: 32-bit/2-stage instance for directed vectors,
// 16-bit/3-stage instance for a seeded random sweep against a reference model.
module tb_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 32-bit, 2-stage instance
  logic        rst_n;
  logic        in_valid, in_ready, signed_mul, cancel, out_valid, out_ready, busy;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [63:0] acc, result;
  logic [3:0]  in_tag, out_tag;

  // 16-bit, 3-stage instance
  logic        d_in_valid, d_in_ready, d_signed, d_cancel, d_out_valid, d_out_ready, d_busy;
  logic [1:0]  d_op;
  logic [15:0] d_a, d_b;
  logic [31:0] d_acc, d_result;
  logic [3:0]  d_tag, d_out_tag;

  mul_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_signed_mul(signed_mul), .i_op(op), .i_multiplier(a), .i_multiplicand(b),
    .i_acc(acc), .i_in_tag(in_tag), .i_cancel(cancel), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_result(result), .o_out_tag(out_tag), .o_busy(busy)
  );

  mul_pipe #(.WIDTH(16), .STAGES(3), .TAG_W(4)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(d_in_valid), .o_in_ready(d_in_ready),
    .i_signed_mul(d_signed), .i_op(d_op), .i_multiplier(d_a), .i_multiplicand(d_b),
    .i_acc(d_acc), .i_in_tag(d_tag), .i_cancel(d_cancel), .o_out_valid(d_out_valid),
    .i_out_ready(d_out_ready), .o_result(d_result), .o_out_tag(d_out_tag), .o_busy(d_busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          stamp;
    logic        lat;
  } sb_t;

  sb_t        sb[$];
  logic [3:0] ret_q[$];
  int         cyc = 0;
  logic       lat_phase = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] ma,
                       input logic [31:0] mb, input logic [63:0] ac, input logic [3:0] t);
    in_valid = 1'b1; signed_mul = s; op = o; a = ma; b = mb; acc = ac; in_tag = t;
  endtask

  function automatic logic [31:0] ref16(input logic s, input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic [31:0] ac);
    logic [31:0] ex, ey, p;
    ex = s ? {{16{x[15]}}, x} : {16'd0, x};
    ey = s ? {{16{y[15]}}, y} : {16'd0, y};
    p  = ex * ey;
    case (o)
      2'd1:    return ac + p;
      2'd2:    return ac - p;
      default: return p;
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand16(input int n);
    d_signed = 1'($urandom_range(0, 1));
    d_op     = 2'($urandom_range(0, 3));
    d_a      = pick16();
    d_b      = pick16();
    d_acc    = $urandom;
    d_tag    = 4'(n);
  endtask

  // Retirement log of the 32-bit instance.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) ret_q.push_back(out_tag);
  end

  // Scoreboard of the 16-bit instance: retire against model, then log new accepts.
  always @(posedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (d_out_valid && d_out_ready) begin
        chk("d16_sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("d16_result", 64'(d_result), 64'(e.res));
          chk("d16_tag", 64'(d_out_tag), 64'(e.tag));
          if (e.lat) chk("d16_latency", 64'(cyc - e.stamp), 64'd3);
        end
      end
      if (d_in_valid && d_in_ready) begin
        e.res   = ref16(d_signed, d_op, d_a, d_b, d_acc);
        e.tag   = d_tag;
        e.stamp = cyc;
        e.lat   = lat_phase;
        sb.push_back(e);
      end
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic        t_s   [8];
  logic [1:0]  t_op  [8];
  logic [31:0] t_a   [8];
  logic [31:0] t_b   [8];
  logic [63:0] t_acc [8];
  logic [63:0] t_exp [8];
  logic        hold;

  initial begin
    t_s[0] = 1'b1; t_op[0] = 2'd0; t_a[0] = 32'hFFFFFFFF; t_b[0] = 32'h2;        t_acc[0] = 64'h0;
    t_exp[0] = 64'hFFFFFFFF_FFFFFFFE;
    t_s[1] = 1'b0; t_op[1] = 2'd0; t_a[1] = 32'hFFFFFFFF; t_b[1] = 32'h2;        t_acc[1] = 64'h0;
    t_exp[1] = 64'h00000001_FFFFFFFE;
    t_s[2] = 1'b1; t_op[2] = 2'd0; t_a[2] = 32'h80000000; t_b[2] = 32'h80000000; t_acc[2] = 64'h0;
    t_exp[2] = 64'h40000000_00000000;
    t_s[3] = 1'b1; t_op[3] = 2'd1; t_a[3] = 32'h3;        t_b[3] = 32'h4;        t_acc[3] = 64'h10;
    t_exp[3] = 64'h1C;
    t_s[4] = 1'b1; t_op[4] = 2'd2; t_a[4] = 32'h1;        t_b[4] = 32'h1;        t_acc[4] = 64'h0;
    t_exp[4] = 64'hFFFFFFFF_FFFFFFFF;
    t_s[5] = 1'b0; t_op[5] = 2'd3; t_a[5] = 32'h5;        t_b[5] = 32'h6;        t_acc[5] = 64'h1234;
    t_exp[5] = 64'h1E;
    t_s[6] = 1'b0; t_op[6] = 2'd1; t_a[6] = 32'hFFFFFFFF; t_b[6] = 32'hFFFFFFFF; t_acc[6] = 64'h1;
    t_exp[6] = 64'hFFFFFFFE_00000002;
    t_s[7] = 1'b1; t_op[7] = 2'd1; t_a[7] = 32'hFFFFFFFF; t_b[7] = 32'hFFFFFFFF; t_acc[7] = 64'hFFFFFFFF_FFFFFFFF;
    t_exp[7] = 64'h0;

    rst_n = 1'b0; in_valid = 1'b0; signed_mul = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    acc = 64'd0; in_tag = 4'd0; cancel = 1'b0; out_ready = 1'b0;
    d_in_valid = 1'b0; d_signed = 1'b0; d_op = 2'd0; d_a = 16'd0; d_b = 16'd0;
    d_acc = 32'd0; d_tag = 4'd0; d_cancel = 1'b0; d_out_ready = 1'b1;
    hold = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Directed arithmetic vectors, one per cycle, result two cycles later
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(t_s[i], t_op[i], t_a[i], t_b[i], t_acc[i], 4'(i));
      else in_valid = 1'b0;
      if (i == 0) begin
        #1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
      end
      step();
      if (i > 0) begin
        chk($sformatf("vec%0d_valid", i - 1), 64'(out_valid), 64'd1);
        chk($sformatf("vec%0d_result", i - 1), result, t_exp[i-1]);
        chk($sformatf("vec%0d_tag", i - 1), 64'(out_tag), 64'(i - 1));
      end
    end
    step();
    chk("vec_drain_valid", 64'(out_valid), 64'd0);
    chk("vec_drain_busy", 64'(busy), 64'd0);

    // Back-pressure: four ops, OUT_READY low for three cycles mid-stream
    ret_q.delete();
    drive(1'b0, 2'd0, 32'd1, 32'd7, 64'd0, 4'd0);
    step();
    drive(1'b0, 2'd0, 32'd2, 32'd7, 64'd0, 4'd1);
    step();
    chk("bp_first_tag", 64'(out_tag), 64'd0);
    out_ready = 1'b0;
    drive(1'b0, 2'd0, 32'd3, 32'd7, 64'd0, 4'd2);
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_tag", 64'(out_tag), 64'd0);
      chk("bp_hold_result", result, 64'd7);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_tag1", 64'(out_tag), 64'd1);
    chk("bp_res1", result, 64'd14);
    drive(1'b0, 2'd0, 32'd4, 32'd7, 64'd0, 4'd3);
    step();
    chk("bp_tag2", 64'(out_tag), 64'd2);
    chk("bp_res2", result, 64'd21);
    in_valid = 1'b0;
    step();
    chk("bp_tag3", 64'(out_tag), 64'd3);
    chk("bp_res3", result, 64'd28);
    step();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);
    chk("bp_retire_count", 64'(ret_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ret_q.size()) chk($sformatf("bp_order%0d", k), 64'(ret_q[k]), 64'(k));
    end

    // CANCEL with two ops in flight and a third presented
    ret_q.delete();
    drive(1'b1, 2'd0, 32'd2, 32'd3, 64'd0, 4'd8);
    step();
    drive(1'b1, 2'd0, 32'd4, 32'd5, 64'd0, 4'd9);
    step();
    chk("cx_pending", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    cancel = 1'b1;
    drive(1'b1, 2'd0, 32'd6, 32'd7, 64'd0, 4'd10);
    #1;
    chk("cx_in_ready", 64'(in_ready), 64'd0);
    step();
    cancel = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("cx_out_valid", 64'(out_valid), 64'd0);
    chk("cx_busy", 64'(busy), 64'd0);
    step();
    chk("cx_after1", 64'(out_valid), 64'd0);
    step();
    chk("cx_after2", 64'(out_valid), 64'd0);
    chk("cx_no_retire", 64'(ret_q.size()), 64'd0);

    // Asynchronous reset between edges with two ops in flight
    drive(1'b1, 2'd0, 32'd9, 32'd9, 64'd0, 4'd11);
    step();
    drive(1'b1, 2'd0, 32'd8, 32'd8, 64'd0, 4'd12);
    step();
    in_valid = 1'b0;
    chk("ar_pending", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_result", result, 64'd0);
    chk("ar_tag", 64'(out_tag), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_no_replay1", 64'(out_valid), 64'd0);
    chk("ar_no_replay_busy", 64'(busy), 64'd0);
    step();
    chk("ar_no_replay2", 64'(out_valid), 64'd0);

    // 16-bit / 3-stage: unstalled stream with latency check
    lat_phase = 1'b1;
    d_out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      d_in_valid = 1'b1;
      rand16(i);
      step();
    end
    d_in_valid = 1'b0;
    for (int w = 0; w < 20 && (sb.size() != 0 || d_busy); w++) step();
    chk("d16_drain_a", 64'(sb.size()), 64'd0);

    // 16-bit / 3-stage: random valid and random OUT_READY
    lat_phase = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      d_out_ready = 1'($urandom_range(0, 3) != 0);
      if (!hold) begin
        d_in_valid = 1'($urandom_range(0, 3) != 0);
        rand16(i);
      end
      #1;
      hold = d_in_valid & ~d_in_ready;
      step();
    end
    d_in_valid = 1'b0;
    d_out_ready = 1'b1;
    for (int w = 0; w < 30 && (sb.size() != 0 || d_busy); w++) step();
    chk("d16_drain_b", 64'(sb.size()), 64'd0);
    chk("d16_idle", 64'(d_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
